// File: rtl/xyj_disp.sv
// Display/annunciator stage: converts the washer's 10-bit elapsed count to BCD by
// iterative double-dabble and drives a multiplexed 4-digit 7-segment display plus alarm buzzer.
module xyj_disp #(
  parameter int unsigned SCAN_DIV = 50000,
  parameter int unsigned BUZZ_DIV = 25000000
) (
  input  logic       cp,
  input  logic       R,
  input  logic [9:0] count,
  input  logic       BJ,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       buzz,
  output logic       busy
);

  localparam int unsigned ScanW = $clog2(SCAN_DIV);
  localparam int unsigned BuzzW = $clog2(BUZZ_DIV);
  localparam logic [ScanW-1:0] ScanMax = ScanW'(SCAN_DIV - 1);
  localparam logic [BuzzW-1:0] BuzzMax = BuzzW'(BUZZ_DIV - 1);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e      state_q, state_d;
  logic [25:0] sh_q, sh_d;
  logic [3:0]  bit_q, bit_d;
  logic [9:0]  cnt_last_q, cnt_last_d;
  logic        valid_q, valid_d;
  logic [15:0] bcd_q, bcd_d;
  logic [25:0] sh_adj;

  logic [ScanW-1:0] scan_q;
  logic [1:0]       idx_q;
  logic [BuzzW-1:0] bdiv_q;
  logic             phase_q;
  logic [3:0]       blank;
  logic [3:0]       digit;

  function automatic logic [15:0] add3(input logic [15:0] b);
    logic [15:0] r;
    r = b;
    for (int i = 0; i < 4; i++) begin
      if (r[4*i +: 4] >= 4'd5) r[4*i +: 4] = r[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 7'h40;
      4'd1:    decode = 7'h79;
      4'd2:    decode = 7'h24;
      4'd3:    decode = 7'h30;
      4'd4:    decode = 7'h19;
      4'd5:    decode = 7'h12;
      4'd6:    decode = 7'h02;
      4'd7:    decode = 7'h78;
      4'd8:    decode = 7'h00;
      4'd9:    decode = 7'h10;
      default: decode = 7'h7F;
    endcase
  endfunction

  // Correct the BCD field before each shift so nibbles carry properly.
  assign sh_adj = {add3(sh_q[25:10]), sh_q[9:0]};

  always_comb begin
    state_d    = state_q;
    sh_d       = sh_q;
    bit_d      = bit_q;
    cnt_last_d = cnt_last_q;
    valid_d    = valid_q;
    bcd_d      = bcd_q;
    case (state_q)
      StIdle: begin
        if (!valid_q || count != cnt_last_q) begin
          sh_d       = {16'b0, count};
          cnt_last_d = count;
          bit_d      = 4'd0;
          state_d    = StShift;
        end
      end
      StShift: begin
        sh_d = {sh_adj[24:0], 1'b0};
        if (bit_q == 4'd9) state_d = StDone;
        else               bit_d   = bit_q + 4'd1;
      end
      StDone: begin
        bcd_d   = sh_q[25:10];
        valid_d = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Leading-zero blanking; everything blank until the first commit.
  always_comb begin
    blank[3] = (bcd_q[15:12] == 4'd0);
    blank[2] = blank[3] && (bcd_q[11:8] == 4'd0);
    blank[1] = blank[2] && (bcd_q[7:4] == 4'd0);
    blank[0] = 1'b0;
    if (!valid_q) blank = 4'hF;
    digit = bcd_q[{idx_q, 2'b00} +: 4];
  end

  always_ff @(posedge cp) begin
    if (R) begin
      state_q    <= StIdle;
      sh_q       <= '0;
      bit_q      <= '0;
      cnt_last_q <= '0;
      valid_q    <= 1'b0;
      bcd_q      <= '0;
      busy       <= 1'b0;
      scan_q     <= '0;
      idx_q      <= '0;
      bdiv_q     <= '0;
      phase_q    <= 1'b1;
      seg        <= 7'h7F;
      an         <= 4'hF;
      buzz       <= 1'b0;
    end else begin
      state_q    <= state_d;
      sh_q       <= sh_d;
      bit_q      <= bit_d;
      cnt_last_q <= cnt_last_d;
      valid_q    <= valid_d;
      bcd_q      <= bcd_d;
      busy       <= (state_d != StIdle);

      if (scan_q == ScanMax) begin
        scan_q <= '0;
        idx_q  <= idx_q + 2'd1;
      end else begin
        scan_q <= scan_q + 1'b1;
      end

      if (BJ) begin
        if (bdiv_q == BuzzMax) begin
          bdiv_q  <= '0;
          phase_q <= ~phase_q;
        end else begin
          bdiv_q <= bdiv_q + 1'b1;
        end
      end else begin
        bdiv_q  <= '0;
        phase_q <= 1'b1;
      end

      seg  <= blank[idx_q] ? 7'h7F : decode(digit);
      an   <= phase_q ? ~(4'b0001 << idx_q) : 4'hF;
      buzz <= BJ && phase_q;
    end
  end

endmodule
